// File: rtl/parking_pkg.sv
// Shared types and constants for the parking pass keypad entry block.
// Segment encodings are active-low, bit order {g,f,e,d,c,b,a}.
package parking_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StGot1,
        StGot2,
        StSend
    } entry_state_e;

    localparam logic [6:0] Seg0     = 7'b1000000;
    localparam logic [6:0] Seg1     = 7'b1111001;
    localparam logic [6:0] Seg2     = 7'b0100100;
    localparam logic [6:0] Seg3     = 7'b0110000;
    localparam logic [6:0] Seg4     = 7'b0011001;
    localparam logic [6:0] Seg5     = 7'b0010010;
    localparam logic [6:0] Seg6     = 7'b0000010;
    localparam logic [6:0] Seg7     = 7'b1111000;
    localparam logic [6:0] Seg8     = 7'b0000000;
    localparam logic [6:0] Seg9     = 7'b0010000;
    localparam logic [6:0] SegP     = 7'b0001100;
    localparam logic [6:0] SegBlank = 7'b1111111;

    localparam logic [3:0] CodeP     = 4'hA;
    localparam logic [3:0] CodeBlank = 4'hF;

    // Display shows how many digits are held, or "P" while the code is offered.
    function automatic logic [3:0] state_to_code(entry_state_e st);
        logic [3:0] code;
        code = CodeBlank;
        unique case (st)
            StIdle:  code = 4'd0;
            StGot1:  code = 4'd1;
            StGot2:  code = 4'd2;
            StSend:  code = CodeP;
            default: code = CodeBlank;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/parking_pass_entry_if.sv
// Keypad strobes and gate-controller handshake for parking_pass_entry.
// The gate/keypad side uses master; the entry block uses slave.
interface parking_pass_entry_if;

    logic       key_valid;
    logic [1:0] key_code;
    logic       key_enter;
    logic       key_clear;
    logic       pass_ready;
    logic       pass_valid;
    logic [1:0] pass_1;
    logic [1:0] pass_2;
    logic       entry_busy;
    logic       timeout_pulse;
    logic [6:0] HEX_E;

    modport master (
        output key_valid,
        output key_code,
        output key_enter,
        output key_clear,
        output pass_ready,
        input  pass_valid,
        input  pass_1,
        input  pass_2,
        input  entry_busy,
        input  timeout_pulse,
        input  HEX_E
    );

    modport slave (
        input  key_valid,
        input  key_code,
        input  key_enter,
        input  key_clear,
        input  pass_ready,
        output pass_valid,
        output pass_1,
        output pass_2,
        output entry_busy,
        output timeout_pulse,
        output HEX_E
    );

endinterface

// File: rtl/seg7_decoder.sv
// 4-bit code to active-low seven-segment pattern: 0-9, "P" and blank.
module seg7_decoder
    import parking_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SegBlank;
        case (code_i)
            4'd0:    seg_o = Seg0;
            4'd1:    seg_o = Seg1;
            4'd2:    seg_o = Seg2;
            4'd3:    seg_o = Seg3;
            4'd4:    seg_o = Seg4;
            4'd5:    seg_o = Seg5;
            4'd6:    seg_o = Seg6;
            4'd7:    seg_o = Seg7;
            4'd8:    seg_o = Seg8;
            4'd9:    seg_o = Seg9;
            CodeP:   seg_o = SegP;
            default: seg_o = SegBlank;
        endcase
    end

endmodule

// File: rtl/parking_pass_entry.sv
// Two-digit keypad entry with inactivity timeout; offers the finished code to
// the gate controller over a valid/ready handshake. All outputs are registered.
module parking_pass_entry
    import parking_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input logic                 clock_in,
    input logic                 rst_in,
    parking_pass_entry_if.slave bus
);

    localparam int unsigned TimerW =
        ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT_CYCLES - 1);

    entry_state_e      state_q, state_d;
    logic [1:0]        pass_1_q, pass_1_d;
    logic [1:0]        pass_2_q, pass_2_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              timeout_q, timeout_d;
    logic              pass_valid_q, pass_valid_d;
    logic              busy_q, busy_d;
    logic [6:0]        hex_q, hex_d;

    logic key_event;
    logic timer_expired;

    assign key_event     = bus.key_valid | bus.key_enter | bus.key_clear;
    assign timer_expired = (timer_q == TimerMax);

    always_comb begin
        state_d   = state_q;
        pass_1_d  = pass_1_q;
        pass_2_d  = pass_2_q;
        timer_d   = timer_q;
        timeout_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!bus.key_clear && bus.key_valid) begin
                    pass_1_d = bus.key_code;
                    timer_d  = '0;
                    state_d  = StGot1;
                end
            end
            StGot1: begin
                if (bus.key_clear) begin
                    state_d  = StIdle;
                    pass_1_d = '0;
                    pass_2_d = '0;
                    timer_d  = '0;
                end else if (bus.key_valid) begin
                    // A simultaneous enter is dropped: the second digit wins.
                    pass_2_d = bus.key_code;
                    timer_d  = '0;
                    state_d  = StGot2;
                end else if (timer_expired && !key_event) begin
                    state_d   = StIdle;
                    pass_1_d  = '0;
                    pass_2_d  = '0;
                    timer_d   = '0;
                    timeout_d = 1'b1;
                end else if (!timer_expired) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StGot2: begin
                if (bus.key_clear) begin
                    state_d  = StIdle;
                    pass_1_d = '0;
                    pass_2_d = '0;
                    timer_d  = '0;
                end else if (bus.key_enter) begin
                    state_d = StSend;
                    timer_d = '0;
                end else if (timer_expired && !key_event) begin
                    state_d   = StIdle;
                    pass_1_d  = '0;
                    pass_2_d  = '0;
                    timer_d   = '0;
                    timeout_d = 1'b1;
                end else if (!timer_expired) begin
                    // Extra digit keys are ignored and do not restart the timer.
                    timer_d = timer_q + 1'b1;
                end
            end
            StSend: begin
                if (bus.pass_ready) begin
                    state_d  = StIdle;
                    pass_1_d = '0;
                    pass_2_d = '0;
                end
            end
            default: begin
                state_d  = StIdle;
                pass_1_d = '0;
                pass_2_d = '0;
                timer_d  = '0;
            end
        endcase

        pass_valid_d = (state_d == StSend);
        busy_d       = (state_d != StIdle);
    end

    seg7_decoder u_seg7_decoder (
        .code_i (state_to_code(state_d)),
        .seg_o  (hex_d)
    );

    always_ff @(posedge clock_in) begin
        if (rst_in) begin
            state_q      <= StIdle;
            pass_1_q     <= '0;
            pass_2_q     <= '0;
            timer_q      <= '0;
            timeout_q    <= 1'b0;
            pass_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            hex_q        <= Seg0;
        end else begin
            state_q      <= state_d;
            pass_1_q     <= pass_1_d;
            pass_2_q     <= pass_2_d;
            timer_q      <= timer_d;
            timeout_q    <= timeout_d;
            pass_valid_q <= pass_valid_d;
            busy_q       <= busy_d;
            hex_q        <= hex_d;
        end
    end

    assign bus.pass_valid    = pass_valid_q;
    assign bus.pass_1        = pass_1_q;
    assign bus.pass_2        = pass_2_q;
    assign bus.entry_busy    = busy_q;
    assign bus.timeout_pulse = timeout_q;
    assign bus.HEX_E         = hex_q;

endmodule

// File: tb/tb_parking_pass_entry.sv
// Scoreboard bench for parking_pass_entry: stimulus pushes expected transfers
// and timeouts, a negedge monitor pops and compares them as they appear.
module tb_parking_pass_entry;

    localparam logic [6:0] H0 = 7'b1000000;
    localparam logic [6:0] H1 = 7'b1111001;
    localparam logic [6:0] H2 = 7'b0100100;
    localparam logic [6:0] HP = 7'b0001100;

    typedef struct {
        bit         is_timeout;
        logic [1:0] p1;
        logic [1:0] p2;
    } exp_t;

    logic clk;
    logic rst_in;
    int   checks;
    int   errors;
    exp_t sb[$];

    parking_pass_entry_if bus ();

    parking_pass_entry #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock_in (clk),
        .rst_in   (rst_in),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [1:0] code);
        bus.key_valid = 1'b1;
        bus.key_code  = code;
        tick();
        bus.key_valid = 1'b0;
        bus.key_code  = 2'd0;
    endtask

    task automatic enter();
        bus.key_enter = 1'b1;
        tick();
        bus.key_enter = 1'b0;
    endtask

    task automatic clear();
        bus.key_clear = 1'b1;
        tick();
        bus.key_clear = 1'b0;
    endtask

    task automatic push(input bit is_to, input logic [1:0] p1, input logic [1:0] p2);
        exp_t e;
        e.is_timeout = is_to;
        e.p1 = p1;
        e.p2 = p2;
        sb.push_back(e);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 32'(bus.pass_valid), 32'd0);
        check({tag, "_digits"}, 32'({bus.pass_1, bus.pass_2}), 32'd0);
        check({tag, "_busy"}, 32'(bus.entry_busy), 32'd0);
        check({tag, "_hex"}, 32'(bus.HEX_E), 32'(H0));
    endtask

    // Monitor: transfers and timeouts are matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst_in) begin
            if (bus.pass_valid && bus.pass_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL transfer: got %0d,%0d expected none", bus.pass_1, bus.pass_2);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.is_timeout || bus.pass_1 !== e.p1 || bus.pass_2 !== e.p2) begin
                        errors++;
                        $display("FAIL transfer: got %0d,%0d expected timeout=%0d %0d,%0d",
                                 bus.pass_1, bus.pass_2, e.is_timeout, e.p1, e.p2);
                    end
                end
            end
            if (bus.timeout_pulse) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL timeout: got pulse expected none");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (!e.is_timeout || bus.pass_1 !== 2'd0 || bus.pass_2 !== 2'd0) begin
                        errors++;
                        $display("FAIL timeout: got pulse digits %0d,%0d expected timeout=%0d",
                                 bus.pass_1, bus.pass_2, e.is_timeout);
                    end
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_in         = 1'b1;
        bus.key_valid  = 1'b0;
        bus.key_code   = 2'd0;
        bus.key_enter  = 1'b0;
        bus.key_clear  = 1'b0;
        bus.pass_ready = 1'b0;
        tick();
        tick();
        check_idle("reset");
        check("reset_timeout", 32'(bus.timeout_pulse), 32'd0);
        rst_in = 1'b0;

        // Basic 1,2 entry, ready two cycles after valid.
        key(2'd1);
        check("got1_p1", 32'(bus.pass_1), 32'd1);
        check("got1_hex", 32'(bus.HEX_E), 32'(H1));
        check("got1_busy", 32'(bus.entry_busy), 32'd1);
        key(2'd2);
        check("got2_p2", 32'(bus.pass_2), 32'd2);
        check("got2_hex", 32'(bus.HEX_E), 32'(H2));
        check("got2_valid", 32'(bus.pass_valid), 32'd0);
        enter();
        check("send_valid", 32'(bus.pass_valid), 32'd1);
        check("send_hex", 32'(bus.HEX_E), 32'(HP));
        push(1'b0, 2'd1, 2'd2);
        tick();
        bus.pass_ready = 1'b1;
        tick();
        bus.pass_ready = 1'b0;
        check_idle("after_xfer");

        // Clear coinciding with a digit key takes priority.
        key(2'd3);
        bus.key_clear = 1'b1;
        key(2'd0);
        bus.key_clear = 1'b0;
        check_idle("clear");

        // Timeout eight cycles after the only key.
        push(1'b1, 2'd0, 2'd0);
        key(2'd2);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("to_pulse_%0d", i), 32'(bus.timeout_pulse), 32'(i == 8));
        end
        check_idle("after_to");
        tick();
        check("to_one_cycle", 32'(bus.timeout_pulse), 32'd0);

        // A key on the expiry cycle wins over the timeout.
        key(2'd2);
        for (int i = 1; i <= 7; i++) tick();
        key(2'd3);
        check("expiry_key_to", 32'(bus.timeout_pulse), 32'd0);
        check("expiry_key_hex", 32'(bus.HEX_E), 32'(H2));
        check("expiry_key_digits", 32'({bus.pass_1, bus.pass_2}), 32'({2'd2, 2'd3}));
        clear();
        check_idle("expiry_clear");

        // Enter together with a digit in GOT1: digit wins.
        key(2'd1);
        bus.key_enter = 1'b1;
        key(2'd2);
        bus.key_enter = 1'b0;
        check("got1_race_hex", 32'(bus.HEX_E), 32'(H2));
        check("got1_race_valid", 32'(bus.pass_valid), 32'd0);
        enter();
        check("got1_race_send", 32'(bus.pass_valid), 32'd1);
        push(1'b0, 2'd1, 2'd2);
        bus.pass_ready = 1'b1;
        tick();
        bus.pass_ready = 1'b0;
        check_idle("race_done");

        // SEND holds for 50 cycles under key noise, then reset mid-SEND.
        key(2'd1);
        key(2'd2);
        enter();
        for (int i = 0; i < 50; i++) begin
            bus.key_valid = 1'($urandom_range(1));
            bus.key_enter = 1'($urandom_range(1));
            bus.key_clear = 1'($urandom_range(1));
            bus.key_code  = 2'($urandom_range(3));
            tick();
            check("send_hold", 32'({bus.pass_valid, bus.pass_1, bus.pass_2}),
                  32'({1'b1, 2'd1, 2'd2}));
        end
        bus.key_valid  = 1'b0;
        bus.key_enter  = 1'b0;
        bus.key_clear  = 1'b0;
        bus.key_code   = 2'd0;
        bus.pass_ready = 1'b1;
        rst_in         = 1'b1;
        tick();
        rst_in         = 1'b0;
        bus.pass_ready = 1'b0;
        check_idle("mid_send_rst");
        check("mid_send_rst_to", 32'(bus.timeout_pulse), 32'd0);

        // Third key in GOT2 and enter in IDLE are ignored.
        key(2'd1);
        key(2'd2);
        key(2'd3);
        check("third_key_digits", 32'({bus.pass_1, bus.pass_2}), 32'({2'd1, 2'd2}));
        check("third_key_hex", 32'(bus.HEX_E), 32'(H2));
        clear();
        enter();
        check_idle("idle_enter");

        // Closing transfer with different digits.
        key(2'd0);
        key(2'd3);
        enter();
        push(1'b0, 2'd0, 2'd3);
        bus.pass_ready = 1'b1;
        tick();
        bus.pass_ready = 1'b0;
        check_idle("final_xfer");
        tick();

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/parking_pass_entry.md
PARKING_PASS_ENTRY -- requirements
Module: parking_pass_entry

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000: idle cycles allowed between key events before a partial entry is discarded.
REQ-002 clock_in  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst_in  input  1  synchronous, active-high reset.
REQ-004 key_valid  input  1  one-cycle strobe: a digit key was pressed.
REQ-005 key_code  input  2  digit value, sampled only when key_valid=1.
REQ-006 key_enter  input  1  one-cycle strobe: submit the entered code.
REQ-007 key_clear  input  1  one-cycle strobe: discard the partial entry.
REQ-008 pass_ready  input  1  gate controller accepts the presented code.
REQ-009 pass_valid  output  1  pass_1/pass_2 hold a complete code for the gate controller.
REQ-010 pass_1  output  2  first entered digit.
REQ-011 pass_2  output  2  second entered digit.
REQ-012 entry_busy  output  1  high in any state other than IDLE.
REQ-013 timeout_pulse  output  1  one-cycle pulse when a partial entry is discarded by timeout.
REQ-014 HEX_E  output  7  active-low seven-segment display of digits held: "0", "1", "2", or "P" while sending.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, GOT1, GOT2 and SEND.
REQ-016 IDLE: key_valid SHALL load key_code into pass_1 and go to GOT1; key_enter SHALL be ignored.
REQ-017 GOT1: key_valid SHALL load key_code into pass_2 and go to GOT2.
REQ-018 GOT2: key_enter SHALL go to SEND; key_valid SHALL be ignored, with digits unchanged and the timer not restarted.
REQ-019 In GOT1 and GOT2, key_clear SHALL return the FSM to IDLE and zero pass_1/pass_2 on the next edge.
REQ-020 When key_clear coincides with key_valid or key_enter, key_clear SHALL take priority in every state; in IDLE the FSM stays IDLE.
REQ-021 When key_enter and key_valid coincide in GOT1, key_valid SHALL win and key_enter SHALL be dropped.
REQ-022 SEND: pass_valid=1, with pass_1/pass_2 held stable and all key inputs ignored.
REQ-023 SEND: pass_ready=1 SHALL complete the transfer; on the next edge the FSM goes to IDLE, pass_valid=0 and the digits are zeroed.
REQ-024 SEND SHALL wait indefinitely for pass_ready, with no timeout.
REQ-025 pass_valid SHALL assert exactly one cycle after key_enter is sampled in GOT2 (registered output).
REQ-026 Timer: a counter of width clog2(TIMEOUT_CYCLES) SHALL reset to 0 on every accepted key_valid and count only in GOT1 and GOT2.
REQ-027 Timeout: when the timer reaches TIMEOUT_CYCLES-1 with no key event that cycle, the FSM SHALL go to IDLE, zero the digits and pulse timeout_pulse for one cycle.
REQ-028 A key event in the same cycle as timer expiry SHALL win over the timeout.
REQ-029 The timer SHALL saturate and never wrap.
REQ-030 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-031 rst_in=1 at a clock edge SHALL force IDLE, timer=0, pass_1=0, pass_2=0, pass_valid=0, entry_busy=0, timeout_pulse=0 and HEX_E="0" (7'b1000000).
REQ-032 Reset SHALL override all inputs, including mid-SEND with pass_ready high; no transfer is reported after reset.

Structure
REQ-033 Package parking_pkg SHALL hold the FSM state enum and the active-low seven-segment constants (digits 0-9, "P", blank).
REQ-034 One sub-module, seg7_decoder (4-bit code to 7-bit active-low segments), SHALL drive HEX_E and be reusable by parking_system.

Verification
REQ-035 Reset, then key 1, key 2, enter, pass_ready=1 two cycles after pass_valid -> pass_1=1, pass_2=2, pass_valid high one cycle after enter, then IDLE with zeroed digits.
REQ-036 Key 3, key_clear together with key 0 -> IDLE, pass_1=0, no pass_valid, HEX_E="0".
REQ-037 TIMEOUT_CYCLES=8, key 2 then idle -> timeout_pulse on the 8th cycle after the key, FSM IDLE, digits 0; a key on the expiry cycle instead yields GOT2.
REQ-038 Code 1,2 held in SEND with pass_ready=0 for 50 cycles while keys toggle -> pass_valid and digits stable; rst_in mid-SEND -> all outputs at reset values next edge.
REQ-039 Third key in GOT2, and enter in IDLE -> both ignored; digits and state unchanged.
